// File: rtl/sys_bridge_n_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sys_bridge_n_pkg : shared encodings, default slot map and helpers -- rev 1.0
// ----------------------------------------------------------------------------
package sys_bridge_n_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam logic [31:0] COUNTER_BASE = 32'h0000_7F00;
  localparam logic [31:0] SWITCH_BASE  = 32'h0000_7F10;
  localparam logic [31:0] LED_BASE     = 32'h0000_7F20;
  localparam logic [31:0] DEV_MASK_DEF = 32'hFFFF_FFF0;

  localparam int DEF_TO_W    = 8;
  localparam int DEF_TIMEOUT = 255;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        wr;
  } req_t;

  function automatic logic slot_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_bridge_n_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sys_bridge_n_if : CPU and device-side bus bundle (BRIDGE_ERR_CAPTURE_EN adds
// error-capture signals) -- rev 1.0
// ----------------------------------------------------------------------------
interface sys_bridge_n_if #(
  parameter int N_DEV = 3
);
  logic                PrReq;
  logic [31:0]         PrAddr;
  logic [31:0]         PrWD;
  logic                PrWr;
  logic [3:0]          PrBE;
  logic [31:0]         PrRD;
  logic                PrReady;
  logic                PrErr;
  logic [31:0]         DEV_Addr;
  logic [31:0]         DEV_WD;
  logic [3:0]          DEV_BE;
  logic [N_DEV-1:0]    DEV_Sel;
  logic [N_DEV-1:0]    DEV_Wr;
  logic [32*N_DEV-1:0] DEV_RD;
  logic [N_DEV-1:0]    DEV_Ack;
`ifdef BRIDGE_ERR_CAPTURE_EN
  logic [31:0]         ErrAddr;
  logic [1:0]          ErrCause;
  logic                ErrClr;

  modport slave (
    input  PrReq, PrAddr, PrWD, PrWr, PrBE, DEV_RD, DEV_Ack, ErrClr,
    output PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_BE, DEV_Sel, DEV_Wr,
           ErrAddr, ErrCause
  );
  modport master (
    output PrReq, PrAddr, PrWD, PrWr, PrBE, DEV_RD, DEV_Ack, ErrClr,
    input  PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_BE, DEV_Sel, DEV_Wr,
           ErrAddr, ErrCause
  );
`else
  modport slave (
    input  PrReq, PrAddr, PrWD, PrWr, PrBE, DEV_RD, DEV_Ack,
    output PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_BE, DEV_Sel, DEV_Wr
  );
  modport master (
    output PrReq, PrAddr, PrWD, PrWr, PrBE, DEV_RD, DEV_Ack,
    input  PrRD, PrReady, PrErr, DEV_Addr, DEV_WD, DEV_BE, DEV_Sel, DEV_Wr
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sys_bridge_n_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sys_bridge_n_decode : base/mask address decode, lowest slot wins -- rev 1.0
// ----------------------------------------------------------------------------
module sys_bridge_n_decode
  import sys_bridge_n_pkg::*;
#(
  parameter int                  N_DEV    = 3,
  parameter logic [32*N_DEV-1:0] DEV_BASE = '0,
  parameter logic [32*N_DEV-1:0] DEV_MASK = '0
) (
  input  logic [31:0]      addr_i,
  output logic [N_DEV-1:0] hit_vec_o,
  output logic             hit_o
);

  logic [N_DEV-1:0] raw_hit;

  for (genvar i = 0; i < N_DEV; i++) begin : g_slot
    assign raw_hit[i] = slot_match(addr_i, DEV_BASE[32*i +: 32], DEV_MASK[32*i +: 32]);
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_vec_o = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (raw_hit[i]) begin
        hit_vec_o = N_DEV'(1) << i;
      end
    end
  end

  assign hit_o = |raw_hit;

endmodule
`default_nettype wire

// File: rtl/sys_bridge_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sys_bridge_n : clocked CPU-to-device bridge with wait states, timeout and bus
// error; define BRIDGE_ERR_CAPTURE_EN for sticky error capture -- rev 1.0
// ----------------------------------------------------------------------------
module sys_bridge_n
  import sys_bridge_n_pkg::*;
#(
  parameter int                  N_DEV    = 3,
  parameter logic [32*N_DEV-1:0] DEV_BASE = {LED_BASE, SWITCH_BASE, COUNTER_BASE},
  parameter logic [32*N_DEV-1:0] DEV_MASK = {N_DEV{DEV_MASK_DEF}},
  parameter int                  TO_W     = DEF_TO_W,
  parameter int                  TIMEOUT  = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  sys_bridge_n_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  req_t             req_q;
  logic [N_DEV-1:0] sel_q;
  logic [31:0]      rd_q;

  logic [N_DEV-1:0] dec_hit_vec;
  logic             dec_hit;
  logic             sel_ack;
  logic [31:0]      sel_rd;
  logic             to_expire;
  logic             in_access;

  sys_bridge_n_decode #(
    .N_DEV    (N_DEV),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decode (
    .addr_i    (bus.PrAddr),
    .hit_vec_o (dec_hit_vec),
    .hit_o     (dec_hit)
  );

  always_comb begin
    sel_rd = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (sel_q[i]) begin
        sel_rd = sel_rd | bus.DEV_RD[32*i +: 32];
      end
    end
  end

  // Only the selected slot may complete the access; strays on other slots are masked.
  assign sel_ack   = |(bus.DEV_Ack & sel_q);
  assign to_expire = (TIMEOUT != 0) && (timer_q == TO_LAST);
  assign in_access = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (bus.PrReq) begin
          state_d = dec_hit ? ST_ACCESS : ST_ERR;
        end
      end
      ST_ACCESS: begin
        if (sel_ack) begin
          state_d = ST_DONE;
        end else if (to_expire) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      req_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if ((state_q == ST_IDLE) && bus.PrReq) begin
        req_q.addr <= bus.PrAddr;
        req_q.wd   <= bus.PrWD;
        req_q.be   <= bus.PrBE;
        req_q.wr   <= bus.PrWr;
        sel_q      <= dec_hit_vec;
      end
      // Read data is held until the next read completes; an error zeroes it.
      if (in_access && sel_ack && !req_q.wr) begin
        rd_q <= sel_rd;
      end else if (state_d == ST_ERR) begin
        rd_q <= '0;
      end
    end
  end

  assign bus.PrRD     = rd_q;
  assign bus.PrReady  = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign bus.PrErr    = (state_q == ST_ERR);
  assign bus.DEV_Addr = in_access ? req_q.addr : '0;
  assign bus.DEV_WD   = in_access ? req_q.wd   : '0;
  assign bus.DEV_BE   = in_access ? req_q.be   : '0;
  assign bus.DEV_Sel  = in_access ? sel_q      : '0;
  assign bus.DEV_Wr   = in_access ? (sel_q & {N_DEV{req_q.wr}}) : '0;

`ifdef BRIDGE_ERR_CAPTURE_EN
  logic [31:0] err_addr_q;
  logic [1:0]  err_cause_q;

  // First error is sticky until cleared; a clear beats a same-cycle capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else if (bus.ErrClr) begin
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else if ((state_d == ST_ERR) && (err_cause_q == CAUSE_NONE)) begin
      err_addr_q  <= (state_q == ST_IDLE) ? bus.PrAddr : req_q.addr;
      err_cause_q <= (state_q == ST_IDLE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
    end
  end

  assign bus.ErrAddr  = err_addr_q;
  assign bus.ErrCause = err_cause_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_bridge_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sys_bridge_n : scoreboard bench for sys_bridge_n with random device
// latency, stray acks and optional BRIDGE_ERR_CAPTURE_EN checks -- rev 1.0
// ----------------------------------------------------------------------------
module tb_sys_bridge_n;

  localparam int N       = 4;
  localparam int TIMEOUT = 4;
  // Slot 3 overlaps slots 0..2 so lowest-index priority is exercised.
  localparam logic [32*N-1:0] BASE_FLAT = {32'h7F00, 32'h7F20, 32'h7F10, 32'h7F00};
  localparam logic [32*N-1:0] MASK_FLAT = {32'hFFFF_FF00, {3{32'hFFFF_FFF0}}};
  localparam logic [31:0] M_BASE [N] = '{32'h7F00, 32'h7F10, 32'h7F20, 32'h7F00};
  localparam logic [31:0] M_MASK [N] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00};

  typedef struct {
    int          issue;
    int          ready_at;
    int          slot;
    bit          err;
    bit          unmapped;
    bit          wr;
    bit          clr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   resp_wait;
  logic [31:0] resp_rd;
  logic [31:0] model_rd;
  logic [31:0] m_eaddr;
  logic [1:0]  m_cause;
  exp_t sb[$];

  sys_bridge_n_if #(.N_DEV(N)) bus ();

  sys_bridge_n #(
    .N_DEV    (N),
    .DEV_BASE (BASE_FLAT),
    .DEV_MASK (MASK_FLAT),
    .TO_W     (8),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i])) return i;
    end
    return -1;
  endfunction

  // Device side: each slot acks after resp_wait stall cycles; other slots ack at random.
  initial begin : p_dev
    int acc_cnt;
    logic [N-1:0] ack;
    logic [32*N-1:0] rdf;
    acc_cnt = 0;
    bus.DEV_Ack = '0;
    bus.DEV_RD = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) rdf[32*i +: 32] = $urandom;
      ack = '0;
      if (!reset && bus.DEV_Sel != '0) begin
        if (acc_cnt == resp_wait) begin
          ack = bus.DEV_Sel;
          for (int i = 0; i < N; i++) if (bus.DEV_Sel[i]) rdf[32*i +: 32] = resp_rd;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
      end
      if ($urandom_range(0, 3) == 0) ack = ack | (N'($urandom) & ~bus.DEV_Sel);
      bus.DEV_Ack = ack;
      bus.DEV_RD  = rdf;
    end
  end

  initial begin : p_mon
    exp_t e;
    logic [N-1:0] exp_sel;
    logic [N-1:0] exp_wr;
    logic [31:0]  exp_addr, exp_wd;
    logic [3:0]   exp_be;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_sel = '0; exp_wr = '0; exp_addr = '0; exp_wd = '0; exp_be = '0;
        if (sb.size() > 0) begin
          e = sb[0];
          if (e.slot >= 0 && cyc > e.issue && cyc < e.ready_at) begin
            exp_sel  = N'(1) << e.slot;
            exp_wr   = e.wr ? exp_sel : '0;
            exp_addr = e.addr;
            exp_wd   = e.wd;
            exp_be   = e.be;
          end
        end
        check("dev_sel", 64'(bus.DEV_Sel), 64'(exp_sel));
        check("dev_wr", 64'(bus.DEV_Wr), 64'(exp_wr));
        check("dev_addr", 64'(bus.DEV_Addr), 64'(exp_addr));
        check("dev_wd", 64'(bus.DEV_WD), 64'(exp_wd));
        check("dev_be", 64'(bus.DEV_BE), 64'(exp_be));
        if (bus.PrReady) begin
          if (sb.size() == 0) begin
            check("ready_while_idle", 64'(bus.PrReady), 64'd0);
          end else begin
            e = sb.pop_front();
            check("latency", 64'(cyc), 64'(e.ready_at));
            check("pr_err", 64'(bus.PrErr), 64'(e.err));
            check("pr_rd", 64'(bus.PrRD), 64'(e.rd));
`ifdef BRIDGE_ERR_CAPTURE_EN
            if (e.err && m_cause == 2'b00 && !(e.clr && e.unmapped)) begin
              m_cause = e.unmapped ? 2'b01 : 2'b10;
              m_eaddr = e.addr;
            end
            check("err_addr", 64'(bus.ErrAddr), 64'(m_eaddr));
            check("err_cause", 64'(bus.ErrCause), 64'(m_cause));
`endif
          end
        end else if (sb.size() > 0 && cyc > sb[0].ready_at) begin
          check("ready_missing", 64'(bus.PrReady), 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    #2;
    sb.delete();
    reset = 1'b1;
    bus.PrReq = 1'b0;
`ifdef BRIDGE_ERR_CAPTURE_EN
    bus.ErrClr = 1'b0;
`endif
    model_rd = '0;
    m_eaddr = '0;
    m_cause = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic do_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input logic [3:0] be, input int w, input logic [31:0] rdv,
                        input bit b2b, input bit clr);
    exp_t e;
    bit   done;
    int   n;
    if (!b2b) begin
      bus.PrReq = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
    bus.PrAddr = a; bus.PrWr = wr; bus.PrWD = wd; bus.PrBE = be; bus.PrReq = 1'b1;
    resp_wait = w;
    resp_rd   = rdv;
    e.issue = b2b ? cyc + 1 : cyc;
    e.slot  = model_decode(a);
    e.addr  = a; e.wr = wr; e.wd = wd; e.be = be;
    e.clr   = clr && !b2b;
    if (e.slot < 0) begin
      e.err = 1'b1; e.unmapped = 1'b1; e.ready_at = e.issue + 1; e.rd = '0;
    end else if (w < TIMEOUT) begin
      e.err = 1'b0; e.unmapped = 1'b0; e.ready_at = e.issue + 2 + w;
      e.rd = wr ? model_rd : rdv;
    end else begin
      e.err = 1'b1; e.unmapped = 1'b0; e.ready_at = e.issue + 1 + TIMEOUT; e.rd = '0;
    end
    model_rd = e.rd;
`ifdef BRIDGE_ERR_CAPTURE_EN
    if (e.clr) begin
      bus.ErrClr = 1'b1;
      m_eaddr = '0;
      m_cause = '0;
    end
`endif
    sb.push_back(e);
    done = 1'b0;
    for (n = 0; n < TIMEOUT + 12 && !done; n++) begin
      @(negedge clk);
      if (cyc > e.issue) begin
`ifdef BRIDGE_ERR_CAPTURE_EN
        bus.ErrClr = 1'b0;
`endif
        if (bus.PrReady) begin
          done = 1'b1;
        end else begin
          // The bridge must work from its latched copy, so disturb the live inputs.
          bus.PrAddr = $urandom; bus.PrWD = $urandom;
          bus.PrBE = 4'($urandom); bus.PrWr = 1'($urandom);
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_budget: no PrReady for addr 0x%08h within %0d cycles", a, n);
      do_reset();
    end
  endtask

  task automatic mid_access_reset();
    exp_t e;
    bus.PrReq = 1'b0;
    @(negedge clk);
    bus.PrAddr = 32'h7F18; bus.PrWr = 1'b1; bus.PrWD = 32'hCAFE_F00D; bus.PrBE = 4'h3;
    bus.PrReq = 1'b1;
    resp_wait = 200;
    e.issue = cyc; e.slot = 1; e.addr = 32'h7F18; e.wr = 1'b1; e.wd = 32'hCAFE_F00D;
    e.be = 4'h3; e.clr = 1'b0; e.err = 1'b1; e.unmapped = 1'b0;
    e.ready_at = cyc + 1 + TIMEOUT; e.rd = '0;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    bus.PrReq = 1'b0;
    #2;
    sb.delete();
    reset = 1'b1;
    #1;
    check("rst_async_sel", 64'(bus.DEV_Sel), 64'd0);
    check("rst_async_wr", 64'(bus.DEV_Wr), 64'd0);
    check("rst_async_addr", 64'(bus.DEV_Addr), 64'd0);
    check("rst_async_ready", 64'(bus.PrReady), 64'd0);
    check("rst_async_rd", 64'(bus.PrRD), 64'd0);
    model_rd = '0; m_eaddr = '0; m_cause = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_random(input int count);
    int          r;
    int          w;
    bit          b2b;
    bit          clr;
    logic [31:0] a;
    for (int t = 0; t < count; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = M_BASE[$urandom_range(0, 2)] | 32'($urandom_range(0, 15));
      else if (r < 8) a = 32'h7F00 | 32'($urandom_range(0, 255));
      else            a = $urandom;
      r = $urandom_range(0, 9);
      w = (r < 7) ? r % 4 : ((r == 7) ? TIMEOUT : 200);
      b2b = ($urandom_range(0, 3) == 0);
      clr = !b2b && ($urandom_range(0, 7) == 0);
      do_txn(a, 1'($urandom), $urandom, 4'($urandom), w, $urandom, b2b, clr);
    end
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    n_checks = 0; n_fail = 0; cyc = 0;
    resp_wait = 0; resp_rd = '0; model_rd = '0; m_eaddr = '0; m_cause = '0;
    reset = 1'b1;
    bus.PrReq = 1'b0; bus.PrAddr = '0; bus.PrWD = '0; bus.PrWr = 1'b0; bus.PrBE = '0;
`ifdef BRIDGE_ERR_CAPTURE_EN
    bus.ErrClr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.PrReady), 64'd0);
    check("rst_err", 64'(bus.PrErr), 64'd0);
    check("rst_rd", 64'(bus.PrRD), 64'd0);
    check("rst_sel", 64'(bus.DEV_Sel), 64'd0);
    check("rst_wd", 64'(bus.DEV_WD), 64'd0);
`ifdef BRIDGE_ERR_CAPTURE_EN
    check("rst_cause", 64'(bus.ErrCause), 64'd0);
`endif
    #2 reset = 1'b0;
    @(negedge clk);

    do_txn(32'h7F14, 1'b0, 32'h0, 4'hF, 0, 32'hA5A5_0001, 1'b0, 1'b0);
    do_txn(32'h7F00, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hDEAD_0000, 1'b0, 1'b0);
    do_txn(32'h7F10, 1'b0, 32'h0, 4'hF, 1, 32'h1111_2222, 1'b0, 1'b0);
    do_txn(32'h7F24, 1'b0, 32'h0, 4'hF, 0, 32'h3333_4444, 1'b1, 1'b0);
    do_txn(32'h7F34, 1'b0, 32'h0, 4'h1, 2, 32'h5555_6666, 1'b0, 1'b0);
    do_txn(32'h7F08, 1'b0, 32'h0, 4'h2, 0, 32'h7777_8888, 1'b0, 1'b0);
    mid_access_reset();
    do_txn(32'h3000, 1'b0, 32'h0, 4'hF, 0, 32'h9999_0000, 1'b0, 1'b0);
    do_txn(32'h7F20, 1'b0, 32'h0, 4'hF, 200, 32'hAAAA_0000, 1'b0, 1'b0);
    do_txn(32'h7F2C, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'hBBBB_0000, 1'b0, 1'b0);
    do_txn(32'h5000, 1'b0, 32'h0, 4'hF, 0, 32'hCCCC_0000, 1'b0, 1'b0);
    do_txn(32'h7F04, 1'b0, 32'h0, 4'hF, 0, 32'hDDDD_0001, 1'b0, 1'b1);
    do_txn(32'h6000, 1'b0, 32'h0, 4'hF, 0, 32'hEEEE_0000, 1'b0, 1'b1);

    run_random(300);

    bus.PrReq = 1'b0;
    repeat (8) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
